// File: rtl/cache_mem_arbiter.sv
// Memory-port arbiter shared by the I-cache and D-cache line controllers.
// Holds a grant for the whole line transaction, then inserts one release
// cycle so a requester can drop an already-served request before the next
// arbitration.
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on
// simultaneous requests. By default the D-cache has fixed priority.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  // I-cache side
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  input  logic [LINE_WIDTH-1:0] i_mem_wdata,
  output logic [LINE_WIDTH-1:0] i_mem_rdata,
  output logic                  i_mem_resp,
  // D-cache side
  input  logic                  d_mem_read,
  input  logic                  d_mem_write,
  input  logic [ADDR_WIDTH-1:0] d_mem_address,
  input  logic [LINE_WIDTH-1:0] d_mem_wdata,
  output logic [LINE_WIDTH-1:0] d_mem_rdata,
  output logic                  d_mem_resp,
  // Physical memory side
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    SIdle,
    SGrantI,
    SGrantD,
    SRelease
  } state_e;

  state_e state_q, state_d;
  logic   i_active, d_active;
  logic   pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q;  // 1: D-cache owned the most recent grant, 0: I-cache
  logic last_d_d;
`endif

  assign i_active = i_mem_read | i_mem_write;
  assign d_active = d_mem_read | d_mem_write;

  // Read data is broadcast; only resp tells a cache the data is theirs.
  assign i_mem_rdata = pmem_rdata;
  assign d_mem_rdata = pmem_rdata;

  // Arbitration decision used in idle: does D win this cycle?
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick_d = d_active & (~i_active | ~last_d_q);
`else
    pick_d = d_active;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SIdle: begin
        if (pick_d) begin
          state_d = SGrantD;
        end else if (i_active) begin
          state_d = SGrantI;
        end
      end
      SGrantI: begin
        if (pmem_resp || !i_active) state_d = SRelease;
      end
      SGrantD: begin
        if (pmem_resp || !d_active) state_d = SRelease;
      end
      SRelease: state_d = SIdle;
      default:  state_d = SIdle;
    endcase
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember the owner as the grant is released (normal end or abort).
  always_comb begin
    last_d_d = last_d_q;
    if (state_d == SRelease) begin
      if (state_q == SGrantI) last_d_d = 1'b0;
      if (state_q == SGrantD) last_d_d = 1'b1;
    end
  end
`endif

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SIdle;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  // Forward the owner's transaction; everything quiet outside a grant.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_mem_resp   = 1'b0;
    d_mem_resp   = 1'b0;
    unique case (state_q)
      SGrantI: begin
        pmem_read    = i_mem_read;
        pmem_write   = i_mem_write;
        pmem_address = i_mem_address;
        pmem_wdata   = i_mem_wdata;
        i_mem_resp   = pmem_resp;
      end
      SGrantD: begin
        pmem_read    = d_mem_read;
        pmem_write   = d_mem_write;
        pmem_address = d_mem_address;
        pmem_wdata   = d_mem_wdata;
        d_mem_resp   = pmem_resp;
      end
      SIdle, SRelease: ;
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  // Owner must never read and write in the same cycle.
  a_i_rw_excl: assert property (@(posedge clk) disable iff (rst)
    (state_q == SGrantI) |-> !(i_mem_read && i_mem_write));
  a_d_rw_excl: assert property (@(posedge clk) disable iff (rst)
    (state_q == SGrantD) |-> !(d_mem_read && d_mem_write));
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: a directed vector table for the
// named scenarios, then randomized traffic against a transaction-level model.
module tb_cache_mem_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  localparam logic [LW-1:0] IWD = {8{16'h1111}};
  localparam logic [LW-1:0] DWD = {16{8'hA5}};
  localparam logic [LW-1:0] RDAT = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_mem_read, i_mem_write, d_mem_read, d_mem_write;
  logic [AW-1:0] i_mem_address, d_mem_address, pmem_address;
  logic [LW-1:0] i_mem_wdata, d_mem_wdata, i_mem_rdata, d_mem_rdata;
  logic [LW-1:0] pmem_wdata, pmem_rdata;
  logic          i_mem_resp, d_mem_resp, pmem_read, pmem_write, pmem_resp;

  always #5 clk = ~clk;

  cache_mem_arbiter #(
    .ADDR_WIDTH(AW),
    .LINE_WIDTH(LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .i_mem_address(i_mem_address),
    .i_mem_wdata  (i_mem_wdata),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_resp   (i_mem_resp),
    .d_mem_read   (d_mem_read),
    .d_mem_write  (d_mem_write),
    .d_mem_address(d_mem_address),
    .d_mem_wdata  (d_mem_wdata),
    .d_mem_rdata  (d_mem_rdata),
    .d_mem_resp   (d_mem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One row = one clock cycle: inputs, then expected outputs in that cycle.
  // own: 0 = nobody forwarded, 1 = I-cache forwarded, 2 = D-cache forwarded.
  typedef struct {
    logic          rst;
    logic          ir, iw;
    logic [AW-1:0] ia;
    logic          dr, dw;
    logic [AW-1:0] da;
    logic          presp;
    logic          e_pr, e_pw;
    logic [AW-1:0] e_pa;
    logic          e_ir, e_dr;
    int            e_own;
  } vec_t;

  function automatic vec_t mk(logic r, logic ir, logic iw, logic [AW-1:0] ia, logic dr, logic dw,
                              logic [AW-1:0] da, logic presp, logic e_pr, logic e_pw,
                              logic [AW-1:0] e_pa, logic e_ir, logic e_dr, int e_own);
    vec_t v;
    v.rst = r; v.ir = ir; v.iw = iw; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
    v.presp = presp; v.e_pr = e_pr; v.e_pw = e_pw; v.e_pa = e_pa;
    v.e_ir = e_ir; v.e_dr = e_dr; v.e_own = e_own;
    return v;
  endfunction

  function automatic logic [LW-1:0] exp_wdata(int own);
    if (own == 1) return IWD;
    if (own == 2) return DWD;
    return '0;
  endfunction

  // Transaction-level reference: who owns the port and how many dead cycles remain.
  int model_owner;   // 0 none, 1 I, 2 D
  int model_gap;     // release cycles still to spend before arbitration
  int model_last;    // last owner released (1 I, 2 D)

  task automatic model_reset();
    model_owner = 0;
    model_gap   = 0;
    model_last  = 1;
  endtask

  task automatic model_step();
    logic ia, da;
    ia = i_mem_read | i_mem_write;
    da = d_mem_read | d_mem_write;
    if (rst) begin
      model_reset();
    end else if (model_owner != 0) begin
      if (pmem_resp || (model_owner == 1 && !ia) || (model_owner == 2 && !da)) begin
        model_last  = model_owner;
        model_owner = 0;
        model_gap   = 1;
      end
    end else if (model_gap > 0) begin
      model_gap--;
    end else if (ia && da) begin
`ifdef ARB_ROUND_ROBIN_EN
      model_owner = (model_last == 1) ? 2 : 1;
`else
      model_owner = 2;
`endif
    end else if (da) begin
      model_owner = 2;
    end else if (ia) begin
      model_owner = 1;
    end
  endtask

  task automatic model_check(int cyc);
    logic          epr, epw, eir, edr;
    logic [AW-1:0] epa;
    logic [LW-1:0] ewd;
    epr = 1'b0; epw = 1'b0; eir = 1'b0; edr = 1'b0; epa = '0; ewd = '0;
    if (model_owner == 1) begin
      epr = i_mem_read; epw = i_mem_write; epa = i_mem_address; ewd = i_mem_wdata;
      eir = pmem_resp;
    end else if (model_owner == 2) begin
      epr = d_mem_read; epw = d_mem_write; epa = d_mem_address; ewd = d_mem_wdata;
      edr = pmem_resp;
    end
    check($sformatf("rnd%0d pmem_read", cyc), LW'(pmem_read), LW'(epr));
    check($sformatf("rnd%0d pmem_write", cyc), LW'(pmem_write), LW'(epw));
    check($sformatf("rnd%0d pmem_address", cyc), LW'(pmem_address), LW'(epa));
    check($sformatf("rnd%0d pmem_wdata", cyc), pmem_wdata, ewd);
    check($sformatf("rnd%0d resp", cyc), LW'({i_mem_resp, d_mem_resp}), LW'({eir, edr}));
    check($sformatf("rnd%0d rdata", cyc), i_mem_rdata ^ d_mem_rdata ^ pmem_rdata, pmem_rdata);
  endtask

  vec_t vecs[35];

  initial begin
    // Single I read at 0x1230, resp on the third grant cycle
    vecs[0]  = mk(0, 1,0,16'h1230, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0, 0);
    vecs[1]  = mk(0, 1,0,16'h1230, 0,0,16'h0000, 0,  1,0,16'h1230, 0,0, 1);
    vecs[2]  = mk(0, 1,0,16'h1230, 0,0,16'h0000, 0,  1,0,16'h1230, 0,0, 1);
    vecs[3]  = mk(0, 1,0,16'h1230, 0,0,16'h0000, 1,  1,0,16'h1230, 1,0, 1);
    vecs[4]  = mk(0, 0,0,16'h0000, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0, 0);
    vecs[5]  = mk(0, 0,0,16'h0000, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0, 0);
    // Single D writeback at 0x4000
    vecs[6]  = mk(0, 0,0,16'h0000, 0,1,16'h4000, 0,  0,0,16'h0000, 0,0, 0);
    vecs[7]  = mk(0, 0,0,16'h0000, 0,1,16'h4000, 0,  0,1,16'h4000, 0,0, 2);
    vecs[8]  = mk(0, 0,0,16'h0000, 0,1,16'h4000, 1,  0,1,16'h4000, 0,1, 2);
    vecs[9]  = mk(0, 0,0,16'h0000, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0, 0);
    // Stale request held through the release cycle
    vecs[10] = mk(0, 1,0,16'h2000, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0, 0);
    vecs[11] = mk(0, 1,0,16'h2000, 0,0,16'h0000, 1,  1,0,16'h2000, 1,0, 1);
    vecs[12] = mk(0, 1,0,16'h2000, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0, 0);
    vecs[13] = mk(0, 0,0,16'h0000, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0, 0);
    vecs[14] = mk(0, 0,0,16'h0000, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0, 0);
    // Simultaneous I and D: D first, I granted after release + idle
    vecs[15] = mk(0, 1,0,16'h1230, 1,0,16'h4000, 0,  0,0,16'h0000, 0,0, 0);
    vecs[16] = mk(0, 1,0,16'h1230, 1,0,16'h4000, 0,  1,0,16'h4000, 0,0, 2);
    vecs[17] = mk(0, 1,0,16'h1230, 1,0,16'h4000, 1,  1,0,16'h4000, 0,1, 2);
    vecs[18] = mk(0, 1,0,16'h1230, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0, 0);
    vecs[19] = mk(0, 1,0,16'h1230, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0, 0);
    vecs[20] = mk(0, 1,0,16'h1230, 0,0,16'h0000, 1,  1,0,16'h1230, 1,0, 1);
    vecs[21] = mk(0, 0,0,16'h0000, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0, 0);
    // Reset in the middle of a D grant
    vecs[22] = mk(0, 0,0,16'h0000, 1,0,16'h4000, 0,  0,0,16'h0000, 0,0, 0);
    vecs[23] = mk(1, 0,0,16'h0000, 1,0,16'h4000, 0,  1,0,16'h4000, 0,0, 2);
    vecs[24] = mk(0, 0,0,16'h0000, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0, 0);
    vecs[25] = mk(0, 1,0,16'h3000, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0, 0);
    vecs[26] = mk(0, 1,0,16'h3000, 0,0,16'h0000, 1,  1,0,16'h3000, 1,0, 1);
    vecs[27] = mk(0, 0,0,16'h0000, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0, 0);
    // Spurious pmem_resp while idle
    vecs[28] = mk(0, 0,0,16'h0000, 0,0,16'h0000, 1,  0,0,16'h0000, 0,0, 0);
    vecs[29] = mk(0, 0,0,16'h0000, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0, 0);
    // D aborts before resp: strobes drop at once, then release
    vecs[30] = mk(0, 0,0,16'h0000, 1,0,16'h5000, 0,  0,0,16'h0000, 0,0, 0);
    vecs[31] = mk(0, 0,0,16'h0000, 1,0,16'h5000, 0,  1,0,16'h5000, 0,0, 2);
    vecs[32] = mk(0, 0,0,16'h0000, 0,0,16'h5000, 0,  0,0,16'h5000, 0,0, 2);
    vecs[33] = mk(0, 1,0,16'h6000, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0, 0);
    vecs[34] = mk(0, 0,0,16'h0000, 0,0,16'h0000, 0,  0,0,16'h0000, 0,0, 0);

    rst = 1'b1;
    i_mem_read = 0; i_mem_write = 0; i_mem_address = '0; i_mem_wdata = IWD;
    d_mem_read = 0; d_mem_write = 0; d_mem_address = '0; d_mem_wdata = DWD;
    pmem_rdata = RDAT; pmem_resp = 0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      rst = vecs[k].rst;
      i_mem_read = vecs[k].ir; i_mem_write = vecs[k].iw; i_mem_address = vecs[k].ia;
      d_mem_read = vecs[k].dr; d_mem_write = vecs[k].dw; d_mem_address = vecs[k].da;
      pmem_resp = vecs[k].presp;
      #1;
      check($sformatf("vec%0d pmem_read", k), LW'(pmem_read), LW'(vecs[k].e_pr));
      check($sformatf("vec%0d pmem_write", k), LW'(pmem_write), LW'(vecs[k].e_pw));
      check($sformatf("vec%0d pmem_address", k), LW'(pmem_address), LW'(vecs[k].e_pa));
      check($sformatf("vec%0d pmem_wdata", k), pmem_wdata, exp_wdata(vecs[k].e_own));
      check($sformatf("vec%0d i_mem_resp", k), LW'(i_mem_resp), LW'(vecs[k].e_ir));
      check($sformatf("vec%0d d_mem_resp", k), LW'(d_mem_resp), LW'(vecs[k].e_dr));
      check($sformatf("vec%0d i_mem_rdata", k), i_mem_rdata, RDAT);
      check($sformatf("vec%0d d_mem_rdata", k), d_mem_rdata, RDAT);
    end

    // Randomized traffic; requesters never raise read and write together.
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      int iop, dop;
      iop = (c % 7 == 0) ? int'($urandom_range(0, 2)) : iop;
      dop = (c % 5 == 0) ? int'($urandom_range(0, 2)) : dop;
      rst = ($urandom_range(0, 99) == 0);
      i_mem_read  = (iop == 1); i_mem_write = (iop == 2);
      d_mem_read  = (dop == 1); d_mem_write = (dop == 2);
      i_mem_address = AW'($urandom); d_mem_address = AW'($urandom);
      i_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      d_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      pmem_rdata  = {$urandom, $urandom, $urandom, $urandom};
      pmem_resp   = ($urandom_range(0, 3) == 0);
      #1;
      model_check(c);
      model_step();
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
